encode_6466b_sm: RTL

//  Registered, parametrised 64b/66b transmit encoder for the 10G PCS, sitting between the MAC/XGMII

---
 rtl/encode_6466b_sm.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/encode_6466b_sm.sv
// ---------------------------------------------------------------------------
// encode_6466b_sm
// Registered 64b/66b transmit encoder for a 10G PCS. XGMII-style beats of
// 32 or 64 bits are assembled into 64-bit blocks. Each block is classified
// as D/S/T/C/E, encoded with a Clause 49 block type and checked by the
// INIT/C/D/T/E transmit state machine. Illegal sequences are replaced by
// error blocks, and a saturating counter records how many were sent.
//
// Ports
//   i_txc        : TX clock; all logic on the rising edge
//   i_reset      : asynchronous, active-high reset
//   i_init_done  : PCS/transceiver init complete; low forces INIT
//   i_txd        : MAC data; byte lane 0 is in [7:0] and goes first on the wire
//   i_txctl      : per-lane control flag (1 = control character)
//   i_tx_pause   : gearbox pause; the beat is not consumed and all state holds
//   o_txd        : encoded block payload (type byte in [7:0] for control blocks)
//   o_tx_header  : sync header (SYNC_DATA or SYNC_CTL)
//   o_tx_state   : current state (0 INIT, 1 C, 2 D, 3 T, 4 E)
//   o_err_count  : error blocks emitted since reset; saturates
//
// The control-code payload is kept byte-aligned. Each lane that carries a
// control code uses one byte (CC_IDLE 0x00, CC_ERROR 0x1E). O-codes and
// padding together use the byte at lane 4.
// ---------------------------------------------------------------------------
module encode_6466b_sm #(
  parameter int DATA_WIDTH    = 64,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      i_txc,
  input  logic                      i_reset,
  input  logic                      i_init_done,
  input  logic [DATA_WIDTH-1:0]     i_txd,
  input  logic [DATA_WIDTH/8-1:0]   i_txctl,
  input  logic                      i_tx_pause,
  output logic [63:0]               o_txd,
  output logic [1:0]                o_tx_header,
  output logic [2:0]                o_tx_state,
  output logic [ERR_CNT_WIDTH-1:0]  o_err_count
);

  localparam logic [1:0]  SYNC_DATA = 2'b01;
  localparam logic [1:0]  SYNC_CTL  = 2'b10;
  localparam logic [7:0]  BT_IDLE   = 8'h1E;
  localparam logic [7:0]  BT_O4     = 8'h2D;
  localparam logic [7:0]  BT_S4     = 8'h33;
  localparam logic [7:0]  BT_O0S4   = 8'h66;
  localparam logic [7:0]  BT_O0O4   = 8'h55;
  localparam logic [7:0]  BT_O0     = 8'h4B;
  localparam logic [7:0]  BT_S0     = 8'h78;
  localparam logic [7:0]  XC_IDLE   = 8'h07;
  localparam logic [7:0]  XC_START  = 8'hFB;
  localparam logic [7:0]  XC_TERM   = 8'hFD;
  localparam logic [7:0]  XC_SEQ    = 8'h9C;
  localparam logic [7:0]  CC_ERROR  = 8'h1E;
  localparam logic [63:0] ERR_BLOCK = {{7{CC_ERROR}}, BT_IDLE};
  localparam logic [1:0]  HK_IDLE   = 2'd0;
  localparam logic [1:0]  HK_OS     = 2'd1;
  localparam logic [1:0]  HK_OTHER  = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0, ST_C = 3'd1, ST_D = 3'd2, ST_T = 3'd3, ST_E = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    CLS_C = 3'd0, CLS_S = 3'd1, CLS_T = 3'd2, CLS_D = 3'd3, CLS_E = 3'd4
  } blk_cls_e;

  // Classify one half of a block: all idle, ordered set in its first lane, or other.
  function automatic logic [1:0] half_kind(input logic [31:0] d, input logic [3:0] c);
    logic [1:0] k;
    if (c == 4'hF && d == {4{XC_IDLE}}) begin
      k = HK_IDLE;
    end else if (c == 4'h1 && d[7:0] == XC_SEQ) begin
      k = HK_OS;
    end else begin
      k = HK_OTHER;
    end
    return k;
  endfunction

  // Block type for a terminate character in lane k.
  function automatic logic [7:0] bt_term(input logic [2:0] k);
    logic [7:0] bt;
    case (k)
      3'd0:    bt = 8'h87;
      3'd1:    bt = 8'h99;
      3'd2:    bt = 8'hAA;
      3'd3:    bt = 8'hB4;
      3'd4:    bt = 8'hCC;
      3'd5:    bt = 8'hD2;
      3'd6:    bt = 8'hE1;
      3'd7:    bt = 8'hFF;
      default: bt = 8'hFF;
    endcase
    return bt;
  endfunction

  logic [63:0] blk_txd_s;
  logic [7:0]  blk_txc_s;
  logic        blk_done_s;

  if (DATA_WIDTH == 64) begin : g_w64
    assign blk_txd_s  = i_txd;
    assign blk_txc_s  = i_txctl;
    assign blk_done_s = 1'b1;
  end else if (DATA_WIDTH == 32) begin : g_w32
    logic        phase_q, phase_d;
    logic [31:0] hold_txd_q, hold_txd_d;
    logic [3:0]  hold_txc_q, hold_txc_d;

    // The first accepted beat of a pair is held; init_done low restarts pairing.
    always_comb begin
      phase_d    = phase_q;
      hold_txd_d = hold_txd_q;
      hold_txc_d = hold_txc_q;
      if (!i_tx_pause) begin
        phase_d = i_init_done ? ~phase_q : 1'b0;
        if (!phase_q) begin
          hold_txd_d = i_txd;
          hold_txc_d = i_txctl;
        end else begin
          hold_txd_d = hold_txd_q;
          hold_txc_d = hold_txc_q;
        end
      end else begin
        phase_d = phase_q;
      end
    end

    // Assembly phase and holding registers.
    always_ff @(posedge i_txc or posedge i_reset) begin
      if (i_reset) begin
        phase_q    <= 1'b0;
        hold_txd_q <= 32'd0;
        hold_txc_q <= 4'd0;
      end else begin
        phase_q    <= phase_d;
        hold_txd_q <= hold_txd_d;
        hold_txc_q <= hold_txc_d;
      end
    end

    assign blk_txd_s  = {i_txd, hold_txd_q};
    assign blk_txc_s  = {i_txctl, hold_txc_q};
    assign blk_done_s = phase_q;
  end else begin : g_bad_width
    $error("encode_6466b_sm: DATA_WIDTH must be 32 or 64");
    assign blk_txd_s  = 64'd0;
    assign blk_txc_s  = 8'd0;
    assign blk_done_s = 1'b0;
  end

  logic [63:0]              txd_q, txd_d;
  logic [1:0]               hdr_q, hdr_d;
  tx_state_e                state_q, state_d, tgt_s;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  blk_cls_e                 cls_s;
  logic [63:0]              enc_s, term_blk_s;
  logic [7:0]               idle_lanes_s, term_hit_s;
  logic [1:0]               hk_lo_s, hk_hi_s;
  logic                     legal_s;

  // Classify the assembled block and build its Clause 49 payload.
  always_comb begin
    hk_lo_s      = half_kind(blk_txd_s[31:0],  blk_txc_s[3:0]);
    hk_hi_s      = half_kind(blk_txd_s[63:32], blk_txc_s[7:4]);
    idle_lanes_s = 8'd0;
    term_hit_s   = 8'd0;
    term_blk_s   = 64'd0;
    for (int j = 0; j < 8; j++) begin
      idle_lanes_s[j] = (blk_txd_s[8*j +: 8] == XC_IDLE);
    end
    // At most one lane can hold a valid /T/: lanes below it are data, lanes above are /I/.
    for (int k = 0; k < 8; k++) begin
      term_hit_s[k] = blk_txc_s[k] && (blk_txd_s[8*k +: 8] == XC_TERM)
                      && ((blk_txc_s & ((8'h01 << k) - 8'h01)) == 8'h00)
                      && ((blk_txc_s & idle_lanes_s & ~((8'h02 << k) - 8'h01))
                          == ~((8'h02 << k) - 8'h01));
      term_blk_s = term_blk_s | ({64{term_hit_s[k]}} &
                   (({blk_txd_s[55:0], 8'h00} & ((64'd1 << (8*(k+1))) - 64'd1)
                     & ~64'h0000_0000_0000_00FF) | {56'd0, bt_term(3'(k))}));
    end

    cls_s = CLS_E;
    enc_s = ERR_BLOCK;
    if (blk_txc_s == 8'h00) begin
      cls_s = CLS_D;
      enc_s = blk_txd_s;
    end else if (blk_txc_s == 8'h01 && blk_txd_s[7:0] == XC_START) begin
      cls_s = CLS_S;
      enc_s = {blk_txd_s[63:8], BT_S0};
    end else if (blk_txc_s[7:4] == 4'h1 && blk_txd_s[39:32] == XC_START && hk_lo_s != HK_OTHER) begin
      cls_s = CLS_S;
      enc_s = (hk_lo_s == HK_IDLE) ? {blk_txd_s[63:40], 8'h00, 24'd0, BT_S4}
                                   : {blk_txd_s[63:40], 8'h00, blk_txd_s[31:8], BT_O0S4};
    end else if (hk_lo_s != HK_OTHER && hk_hi_s != HK_OTHER) begin
      cls_s = CLS_C;
      case ({hk_lo_s, hk_hi_s})
        {HK_IDLE, HK_IDLE}: enc_s = {56'd0, BT_IDLE};
        {HK_IDLE, HK_OS}:   enc_s = {blk_txd_s[63:40], 8'h00, 24'd0, BT_O4};
        {HK_OS, HK_OS}:     enc_s = {blk_txd_s[63:40], 8'h00, blk_txd_s[31:8], BT_O0O4};
        {HK_OS, HK_IDLE}:   enc_s = {24'd0, 8'h00, blk_txd_s[31:8], BT_O0};
        default:            enc_s = ERR_BLOCK;
      endcase
    end else if (term_hit_s != 8'h00) begin
      cls_s = CLS_T;
      enc_s = term_blk_s;
    end else begin
      cls_s = CLS_E;
      enc_s = ERR_BLOCK;
    end
  end

  // Transition legality and the state a legal block leads to.
  always_comb begin
    case (state_q)
      ST_INIT, ST_C, ST_T: legal_s = (cls_s == CLS_C) || (cls_s == CLS_S);
      ST_D:                legal_s = (cls_s == CLS_D) || (cls_s == CLS_T);
      ST_E:                legal_s = (cls_s != CLS_E);
      default:             legal_s = 1'b0;
    endcase
    case (cls_s)
      CLS_C:   tgt_s = ST_C;
      CLS_S:   tgt_s = ST_D;
      CLS_D:   tgt_s = ST_D;
      CLS_T:   tgt_s = ST_T;
      default: tgt_s = ST_E;
    endcase
  end

  // Next output block, state and error count; a paused edge changes nothing.
  always_comb begin
    txd_d   = txd_q;
    hdr_d   = hdr_q;
    state_d = state_q;
    err_d   = err_q;
    if (i_tx_pause) begin
      state_d = state_q;
    end else if (!i_init_done) begin
      state_d = ST_INIT;
      if (blk_done_s) begin
        txd_d = ERR_BLOCK;
        hdr_d = SYNC_CTL;
      end else begin
        txd_d = txd_q;
      end
    end else if (blk_done_s) begin
      if (legal_s) begin
        txd_d   = enc_s;
        hdr_d   = (cls_s == CLS_D) ? SYNC_DATA : SYNC_CTL;
        state_d = tgt_s;
      end else begin
        txd_d   = ERR_BLOCK;
        hdr_d   = SYNC_CTL;
        state_d = ST_E;
        err_d   = (err_q == {ERR_CNT_WIDTH{1'b1}}) ? err_q : err_q + ERR_CNT_WIDTH'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output block, state and counter registers.
  always_ff @(posedge i_txc or posedge i_reset) begin
    if (i_reset) begin
      txd_q   <= ERR_BLOCK;
      hdr_q   <= SYNC_CTL;
      state_q <= ST_INIT;
      err_q   <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      txd_q   <= txd_d;
      hdr_q   <= hdr_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign o_txd       = txd_q;
  assign o_tx_header = hdr_q;
  assign o_tx_state  = state_q;
  assign o_err_count = err_q;

endmodule
